// File: rtl/bist_march_seq.sv
// March-test BIST sequencer for the SRAM behind MEMCTRL: March C-, MATS+ or checkerboard.
// One op per cycle; read compare lands RD_LAT cycles after issue; no backpressure, BIST_EN=0 aborts.
module bist_march_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              BIST_EN,
  input  logic [2:0]        BIST_MODE,
  output logic              MEM_CSB,
  output logic              MEM_WEB,
  output logic              MEM_OEB,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BIST_BUSY,
  output logic              BIST_DONE,
  output logic              BIST_PASS,
  output logic [ADDR_W-1:0] FAIL_ADDR
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic last;
    logic dn;
    logic two;
    logic rd0;
    logic inv0;
    logic rd1;
    logic inv1;
  } elem_t;

  function automatic elem_t elem_info(input logic [2:0] mode, input logic [2:0] idx);
    elem_t e;
    e = 7'b1000000;
    case (mode)
      3'b001: case (idx)
        3'd0: e = 7'b0000000;
        3'd1: e = 7'b0011001;
        3'd2: e = 7'b0011100;
        3'd3: e = 7'b0111001;
        3'd4: e = 7'b0111100;
        3'd5: e = 7'b1001000;
        default: e = 7'b1000000;
      endcase
      3'b010: case (idx)
        3'd0: e = 7'b0000000;
        3'd1: e = 7'b0011001;
        3'd2: e = 7'b1111100;
        default: e = 7'b1000000;
      endcase
      3'b100: case (idx)
        3'd0: e = 7'b0000000;
        3'd1: e = 7'b0001000;
        3'd2: e = 7'b0000100;
        3'd3: e = 7'b1001100;
        default: e = 7'b1000000;
      endcase
      default: e = 7'b1000000;
    endcase
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] ckbd(input logic odd);
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) p[i] = logic'(i % 2 == 0) ^ odd;
    return p;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                opi_q, opi_d;
  logic [1:0]          drain_q, drain_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic                csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [RD_LAT-1:0]   pv_q, pv_d;
  logic [DATA_W-1:0]   pe_q [RD_LAT];
  logic [DATA_W-1:0]   pe_d [RD_LAT];
  logic [ADDR_W-1:0]   pa_q [RD_LAT];
  logic [ADDR_W-1:0]   pa_d [RD_LAT];

  elem_t             cur;
  logic              rd, inv, final_op, mismatch, legal;
  logic [ADDR_W-1:0] phys;
  logic [DATA_W-1:0] base, data;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    elem_d      = elem_q;
    cnt_d       = cnt_q;
    opi_d       = opi_q;
    drain_d     = drain_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    oeb_d       = 1'b1;
    addr_d      = '0;
    wdata_d     = '0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    pv_d        = '0;
    pe_d[0]     = '0;
    pa_d[0]     = '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pa_d[i] = pa_q[i-1];
    end

    cur      = elem_info(mode_q, elem_q);
    rd       = opi_q ? cur.rd1 : cur.rd0;
    inv      = opi_q ? cur.inv1 : cur.inv0;
    final_op = !cur.two || opi_q;
    // Down elements count up internally and invert, so the counter only ever wraps at N-1.
    phys     = cur.dn ? ~cnt_q : cnt_q;
    base     = mode_q[2] ? ckbd(phys[0]) : '0;
    data     = inv ? ~base : base;
    mismatch = pv_q[RD_LAT-1] && (MEM_RDATA != pe_q[RD_LAT-1]);
    legal    = (BIST_MODE == 3'b001) || (BIST_MODE == 3'b010) || (BIST_MODE == 3'b100);

    if ((state_q == S_RUN || state_q == S_DRAIN) && mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = pa_q[RD_LAT-1];
    end

    case (state_q)
      S_IDLE: begin
        if (BIST_EN) begin
          fail_d      = 1'b0;
          fail_addr_d = '0;
          if (legal) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            mode_d  = BIST_MODE;
            elem_d  = '0;
            cnt_d   = '0;
            opi_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        csb_d   = 1'b0;
        web_d   = rd;
        oeb_d   = ~rd;
        addr_d  = phys;
        wdata_d = rd ? '0 : data;
        pv_d[0] = rd;
        pe_d[0] = data;
        pa_d[0] = phys;
        if (!final_op) begin
          opi_d = 1'b1;
        end else begin
          opi_d = 1'b0;
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            elem_d = elem_q + 3'd1;
            if (cur.last) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'(RD_LAT - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~fail_d;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE: begin
        if (!BIST_EN) begin
          state_d     = S_IDLE;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over anything the RUN/DRAIN branches decided this cycle.
    if ((state_q == S_RUN || state_q == S_DRAIN) && !BIST_EN) begin
      state_d     = S_IDLE;
      csb_d       = 1'b1;
      web_d       = 1'b1;
      oeb_d       = 1'b1;
      addr_d      = '0;
      wdata_d     = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      fail_addr_d = '0;
      pv_d        = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      elem_q      <= '0;
      cnt_q       <= '0;
      opi_q       <= 1'b0;
      drain_q     <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      pv_q        <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pe_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      elem_q      <= elem_d;
      cnt_q       <= cnt_d;
      opi_q       <= opi_d;
      drain_q     <= drain_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      pv_q        <= pv_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pe_q[i] <= pe_d[i];
        pa_q[i] <= pa_d[i];
      end
    end
  end

  assign MEM_CSB   = csb_q;
  assign MEM_WEB   = web_q;
  assign MEM_OEB   = oeb_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign BIST_BUSY = busy_q;
  assign BIST_DONE = done_q;
  assign BIST_PASS = pass_q;
  assign FAIL_ADDR = fail_addr_q;

endmodule
